// File: rtl/varredura_matriz_if.sv
// Signal bundle between the board controller side and the LED matrix scanner.
// The scanner consumes the board columns and cursor, and drives the matrix pins.
interface varredura_matriz_if;
  logic       ligado;
  logic [6:0] coluna1;
  logic [6:0] coluna2;
  logic [6:0] coluna3;
  logic [6:0] coluna4;
  logic [6:0] coluna5;
  logic       cursor_ativo;
  logic [2:0] cursor_coluna;
  logic [2:0] cursor_linha;
  logic [4:0] colunas;
  logic [6:0] linhas;
  logic       frame_inicio;

  modport master (
    output ligado, coluna1, coluna2, coluna3, coluna4, coluna5,
    output cursor_ativo, cursor_coluna, cursor_linha,
    input  colunas, linhas, frame_inicio
  );

  modport slave (
    input  ligado, coluna1, coluna2, coluna3, coluna4, coluna5,
    input  cursor_ativo, cursor_coluna, cursor_linha,
    output colunas, linhas, frame_inicio
  );
endinterface

// File: rtl/varredura_matriz.sv
// 5x7 LED matrix column scanner: per-frame double-buffered board, blanking at
// the start of each column slot, and a blinking XOR cursor cell.
module varredura_matriz #(
  parameter int DIV_COLUNA    = 5000,
  parameter int TEMPO_APAGADO = 250,
  parameter int DIV_PISCA     = 25
) (
  input  logic                clock,
  input  logic                reset,
  varredura_matriz_if.slave   bus
);

  localparam int CW = (DIV_COLUNA > 1) ? $clog2(DIV_COLUNA) : 1;
  localparam int QW = (DIV_PISCA > 1) ? $clog2(DIV_PISCA) : 1;

  logic [CW-1:0] ciclo_q, ciclo_d;
  logic [2:0]    idx_q, idx_d;
  logic [QW-1:0] quadros_q, quadros_d;
  logic          fase_q, fase_d;
  logic [6:0]    buffer_q [5];
  logic [6:0]    buffer_d [5];
  logic [4:0]    colunas_q, colunas_d;
  logic [6:0]    linhas_q, linhas_d;
  logic          frame_q, frame_d;

  logic          inicio;
  logic          cursor_ok;
  logic [6:0]    mascara;

  // Cursor is sampled live; out-of-range coordinates never match any column.
  assign cursor_ok = bus.cursor_ativo && fase_q &&
                     (bus.cursor_coluna >= 3'd1) && (bus.cursor_coluna <= 3'd5) &&
                     (bus.cursor_linha  >= 3'd1) && (bus.cursor_linha  <= 3'd7) &&
                     (bus.cursor_coluna == idx_q + 3'd1);
  assign mascara = cursor_ok ? (7'd1 << (bus.cursor_linha - 3'd1)) : 7'd0;
  assign inicio  = (idx_q == 3'd0) && (ciclo_q == '0);

  always_comb begin
    ciclo_d   = ciclo_q;
    idx_d     = idx_q;
    quadros_d = quadros_q;
    fase_d    = fase_q;
    buffer_d  = buffer_q;
    colunas_d = 5'd0;
    linhas_d  = 7'h7F;
    frame_d   = 1'b0;

    if (!bus.ligado) begin
      ciclo_d   = '0;
      idx_d     = 3'd0;
      quadros_d = '0;
      fase_d    = 1'b0;
    end else begin
      frame_d = inicio;
      // The only moment the displayed board may change: start of column 1.
      if (inicio) begin
        buffer_d[0] = bus.coluna1;
        buffer_d[1] = bus.coluna2;
        buffer_d[2] = bus.coluna3;
        buffer_d[3] = bus.coluna4;
        buffer_d[4] = bus.coluna5;
      end

      if (ciclo_q >= CW'(TEMPO_APAGADO)) begin
        colunas_d = 5'd1 << idx_q;
        linhas_d  = buffer_q[idx_q] ^ mascara;
      end

      if (ciclo_q == CW'(DIV_COLUNA - 1)) begin
        ciclo_d = '0;
        if (idx_q == 3'd4) begin
          idx_d = 3'd0;
          if (quadros_q == QW'(DIV_PISCA - 1)) begin
            quadros_d = '0;
            fase_d    = ~fase_q;
          end else begin
            quadros_d = quadros_q + QW'(1);
          end
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        ciclo_d = ciclo_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ciclo_q   <= '0;
      idx_q     <= 3'd0;
      quadros_q <= '0;
      fase_q    <= 1'b0;
      for (int i = 0; i < 5; i++) buffer_q[i] <= 7'h7F;
      colunas_q <= 5'd0;
      linhas_q  <= 7'h7F;
      frame_q   <= 1'b0;
    end else begin
      ciclo_q   <= ciclo_d;
      idx_q     <= idx_d;
      quadros_q <= quadros_d;
      fase_q    <= fase_d;
      buffer_q  <= buffer_d;
      colunas_q <= colunas_d;
      linhas_q  <= linhas_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.colunas      = colunas_q;
  assign bus.linhas       = linhas_q;
  assign bus.frame_inicio = frame_q;

endmodule

// File: tb/tb_varredura_matriz.sv
// Directed bench for varredura_matriz with DIV_COLUNA=8, TEMPO_APAGADO=2, DIV_PISCA=2.
module tb_varredura_matriz;

  localparam int DIVC = 8;
  localparam int TAPG = 2;
  localparam int FRAME = 5 * DIVC;

  logic clock;
  logic reset;
  varredura_matriz_if bus ();

  varredura_matriz #(
    .DIV_COLUNA    (DIVC),
    .TEMPO_APAGADO (TAPG),
    .DIV_PISCA     (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock/reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks   = 0;
  int failures = 0;

  logic [6:0]  exp_buf [5];
  int          exp_mcol;
  logic [6:0]  exp_mask;
  int          chg_at;
  logic [6:0]  chg_val;
  logic [12:0] exp_q [$];

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed={fi,col,lin}=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Expected output stream {frame_inicio, colunas, linhas} for the next n cycles,
  // starting from the capture edge that follows the current negedge.
  task automatic check_frame(input string tag, input int n);
    int c, s;
    logic [6:0] m;
    logic [12:0] e;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      c = k / DIVC;
      s = k % DIVC;
      if (s < TAPG) begin
        e = {1'(k == 0), 5'd0, 7'h7F};
      end else begin
        m = (exp_mcol == c + 1) ? exp_mask : 7'h00;
        e = {1'b0, 5'(1 << c), exp_buf[c] ^ m};
      end
      exp_q.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      check($sformatf("%s k=%0d", tag, k), {bus.frame_inicio, bus.colunas, bus.linhas},
            exp_q.pop_front());
      if (k == chg_at) bus.coluna3 = chg_val;
    end
  endtask

  task automatic check_dark(input string tag);
    check(tag, {bus.frame_inicio, bus.colunas, bus.linhas}, {1'b0, 5'd0, 7'h7F});
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    @(negedge clock);
    check_dark(tag);
    reset = 1'b0;
  endtask

  task automatic set_board(input logic [6:0] c1, input logic [6:0] c2, input logic [6:0] c3,
                           input logic [6:0] c4, input logic [6:0] c5);
    bus.coluna1 = c1; bus.coluna2 = c2; bus.coluna3 = c3; bus.coluna4 = c4; bus.coluna5 = c5;
    exp_buf[0] = c1; exp_buf[1] = c2; exp_buf[2] = c3; exp_buf[3] = c4; exp_buf[4] = c5;
  endtask

  task automatic set_cursor(input logic a, input logic [2:0] col, input logic [2:0] lin);
    bus.cursor_ativo  = a;
    bus.cursor_coluna = col;
    bus.cursor_linha  = lin;
  endtask

  initial begin
    exp_mcol = 0;
    exp_mask = 7'h00;
    chg_at   = -1;
    chg_val  = 7'h00;

    // 1: reset held with ligado=1 and a lit column present
    reset = 1'b1;
    bus.ligado = 1'b1;
    set_board(7'h00, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    set_cursor(1'b0, 3'd0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_dark($sformatf("reset%0d", i));
    end

    // 2: plain scan, two frames
    reset = 1'b0;
    set_board(7'b1111110, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    check_frame("scan_f0", FRAME);
    check_frame("scan_f1", FRAME);

    // 3: column 3 changes mid-frame; shown only from the next frame
    chg_at  = 12;
    chg_val = 7'h00;
    check_frame("tear_old", FRAME);
    chg_at = -1;
    exp_buf[2] = 7'h00;
    check_frame("tear_new", FRAME);

    // 4: blinking cursor at (3,4) on a dark cell, then on a lit cell
    set_board(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    pulse_reset("blink_rst_a");
    set_cursor(1'b1, 3'd3, 3'd4);
    exp_mask = 7'b0001000;
    for (int f = 0; f < 4; f++) begin
      exp_mcol = (f >= 2) ? 3 : 0;
      check_frame($sformatf("blink_dark_f%0d", f), FRAME);
    end
    set_board(7'h7F, 7'h7F, 7'b1110111, 7'h7F, 7'h7F);
    pulse_reset("blink_rst_b");
    for (int f = 0; f < 4; f++) begin
      exp_mcol = (f >= 2) ? 3 : 0;
      check_frame($sformatf("blink_lit_f%0d", f), FRAME);
    end

    // 5: invalid cursor coordinates never alter the board
    exp_mcol = 0;
    set_board(7'b1111110, 7'h55, 7'h2A, 7'h7F, 7'h00);
    pulse_reset("inv_rst_a");
    set_cursor(1'b1, 3'd0, 3'd4);
    for (int f = 0; f < 4; f++) check_frame($sformatf("inv_c0_f%0d", f), FRAME);
    pulse_reset("inv_rst_b");
    set_cursor(1'b1, 3'd6, 3'd1);
    for (int f = 0; f < 4; f++) check_frame($sformatf("inv_c6_f%0d", f), FRAME);
    pulse_reset("inv_rst_c");
    set_cursor(1'b1, 3'd2, 3'd0);
    for (int f = 0; f < 4; f++) check_frame($sformatf("inv_r0_f%0d", f), FRAME);

    // 6: ligado dropped during a column-2 lit cycle, then reset in the same spot
    set_cursor(1'b0, 3'd0, 3'd0);
    check_frame("lig_pre", 13);
    bus.ligado = 1'b0;
    @(negedge clock);
    check_dark("lig_off0");
    @(negedge clock);
    check_dark("lig_off1");
    bus.ligado = 1'b1;
    check_frame("lig_back", FRAME);
    check_frame("rst_pre", 13);
    pulse_reset("rst_mid");
    check_frame("rst_back", FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
